// File: rtl/timer_score_display.sv
// timer_score_display
// Drives a 4-digit multiplexed, active-low 7-segment display with the game
// score on digits 3..2 and the remaining seconds on digits 1..0.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   seconds    remaining seconds 0..31
//   game_over  countdown expired; seconds digits blink while set
//   score      running score 0..127, shown saturated at 99
//   seg        active-low segments, seg[0]=a .. seg[6]=g
//   dp         active-low decimal point (low-time warning on digit 0)
//   an         active-low digit enables, an[0] = rightmost digit
//
// Converter states:
//   state     | meaning
//   S_IDLE    | wait for a {score, seconds} pair different from the last one
//   S_CONVERT | subtract 10 from each working value until both are < 10
//   S_DONE    | commit all four BCD digits together
module timer_score_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_DIV    = 25000000,
  parameter int WARN_SECONDS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] seconds,
  input  logic       game_over,
  input  logic [6:0] score,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} conv_state_t;

  conv_state_t state, state_nxt;

  logic [4:0] seconds_r;
  logic       game_over_r;
  logic [6:0] score_r;
  logic [6:0] score_sat;

  logic [6:0] last_score;
  logic [4:0] last_sec;
  logic [6:0] w_score, red_score;
  logic [4:0] w_sec, red_sec;
  logic [3:0] t_score, t_sec;
  logic       start_conv;

  logic [3:0] bcd_score_tens, bcd_score_ones, bcd_sec_tens, bcd_sec_ones;

  logic [RW-1:0] refresh_cnt;
  logic          refresh_wrap;
  logic [1:0]    digit_idx, idx_nxt;
  logic [BW-1:0] blink_cnt;
  logic          blink_wrap, blink_phase, blink_phase_nxt;

  logic [3:0] bcd_sel;
  logic       blank;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [3:0] an_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Input stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seconds_r   <= '0;
      game_over_r <= 1'b0;
      score_r     <= '0;
    end else begin
      seconds_r   <= seconds;
      game_over_r <= game_over;
      score_r     <= score;
    end
  end

  assign score_sat  = (score_r > 7'd99) ? 7'd99 : score_r;
  assign start_conv = ({score_sat, seconds_r} != {last_score, last_sec});
  assign red_score  = (w_score >= 7'd10) ? w_score - 7'd10 : w_score;
  assign red_sec    = (w_sec >= 5'd10) ? w_sec - 5'd10 : w_sec;

  // Converter FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_conv) state_nxt = S_CONVERT;
      // Leave on the cycle of the last subtraction so 99 takes 9 cycles here.
      S_CONVERT: if (red_score < 7'd10 && red_sec < 5'd10) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // The converted pair is recorded at latch time; inputs are not sampled
  // again until IDLE, so this is indistinguishable from recording in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_score     <= '0;
      last_sec       <= '0;
      w_score        <= '0;
      w_sec          <= '0;
      t_score        <= '0;
      t_sec          <= '0;
      bcd_score_tens <= '0;
      bcd_score_ones <= '0;
      bcd_sec_tens   <= '0;
      bcd_sec_ones   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_conv) begin
            last_score <= score_sat;
            last_sec   <= seconds_r;
            w_score    <= score_sat;
            w_sec      <= seconds_r;
            t_score    <= '0;
            t_sec      <= '0;
          end
        end
        S_CONVERT: begin
          w_score <= red_score;
          w_sec   <= red_sec;
          if (w_score >= 7'd10) t_score <= t_score + 4'd1;
          if (w_sec >= 5'd10)   t_sec   <= t_sec + 4'd1;
        end
        S_DONE: begin
          bcd_score_tens <= t_score;
          bcd_score_ones <= w_score[3:0];
          bcd_sec_tens   <= t_sec;
          bcd_sec_ones   <= w_sec[3:0];
        end
        default: ;
      endcase
    end
  end

  // Scan and blink dividers
  assign refresh_wrap    = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign idx_nxt         = refresh_wrap ? digit_idx + 2'd1 : digit_idx;
  assign blink_wrap      = (blink_cnt == BW'(BLINK_DIV - 1));
  assign blink_phase_nxt = blink_phase ^ blink_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
      digit_idx   <= idx_nxt;
      blink_cnt   <= blink_wrap ? '0 : blink_cnt + BW'(1);
      blink_phase <= blink_phase_nxt;
    end
  end

  // Output content is built from the upcoming index/phase so an, seg and dp
  // all switch on the same edge.
  always_comb begin
    bcd_sel = '0;
    blank   = 1'b0;
    case (idx_nxt)
      2'd0: begin
        bcd_sel = bcd_sec_ones;
        blank   = game_over_r & blink_phase_nxt;
      end
      2'd1: begin
        bcd_sel = bcd_sec_tens;
        blank   = game_over_r & blink_phase_nxt;
      end
      2'd2: bcd_sel = bcd_score_ones;
      2'd3: begin
        bcd_sel = bcd_score_tens;
        blank   = (bcd_score_tens == 4'd0);
      end
      default: ;
    endcase
    seg_nxt = blank ? 7'h7F : seg_decode(bcd_sel);
    dp_nxt  = !((idx_nxt == 2'd0) && !game_over_r && (int'(seconds_r) <= WARN_SECONDS));
    an_nxt  = ~(4'b0001 << idx_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_timer_score_display.sv
// Bench for timer_score_display with short dividers (REFRESH_DIV=4,
// BLINK_DIV=16). Stimulus pushes expected digit presentations into a queue;
// a monitor pops one entry each time the digit enable changes.
module tb_timer_score_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] seconds;
  logic       game_over;
  logic [6:0] score;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  timer_score_display #(.REFRESH_DIV(4), .BLINK_DIV(16), .WARN_SECONDS(5)) dut (
    .clk(clk), .rst_n(rst_n), .seconds(seconds), .game_over(game_over),
    .score(score), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // Edges since reset release; frame m (16 cycles) starts at edge 16*m.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  logic [3:0] an_prev = 4'b1111;
  int         last_chg = 0;
  exp_t       e;
  always @(negedge clk) begin
    if (an !== an_prev) begin
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        check({e.name, " an"}, 32'(an), 32'(e.an));
        check({e.name, " seg"}, 32'(seg), 32'(e.seg));
        check({e.name, " dp"}, 32'(dp), 32'(e.dp));
        check({e.name, " period"}, cyc - last_chg, 4);
      end
      last_chg = cyc;
      an_prev  = an;
    end
  end

  task automatic wait_an(input logic [3:0] v);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an === v) found = 1'b1;
    end
    if (!found) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_an timeout: an=%b expected %b", an, v);
    end
    #1;
  endtask

  // Push nf consecutive frames; when blink is set, digits 1..0 are blank in
  // frames whose blink phase (frame number parity) is 1.
  task automatic push_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic dp0,
                            input bit blink, input int nf);
    bit drained = 1'b0;
    wait_an(4'b0111);
    for (int j = 0; j < nf; j++) begin
      bit ph;
      ph = blink && ((((cyc / 16) + 1 + j) % 2) == 1);
      q.push_back('{an: 4'b1110, seg: ph ? SB : s0, dp: dp0,  name: $sformatf("%s f%0d d0", name, j)});
      q.push_back('{an: 4'b1101, seg: ph ? SB : s1, dp: 1'b1, name: $sformatf("%s f%0d d1", name, j)});
      q.push_back('{an: 4'b1011, seg: s2,           dp: 1'b1, name: $sformatf("%s f%0d d2", name, j)});
      q.push_back('{an: 4'b0111, seg: s3,           dp: 1'b1, name: $sformatf("%s f%0d d3", name, j)});
    end
    for (int i = 0; i < 24 * nf && !drained; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) drained = 1'b1;
    end
    if (!drained) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: %0d expected presentations never seen", name, q.size());
      q.delete();
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   first17, first42, mixed;
    logic [7:0] v;

    seconds   = 5'd30;
    game_over = 1'b0;
    score     = 7'd0;
    rst_n     = 1'b0;
    settle(3);
    check("rst an", 32'(an), 32'h0000000F);
    check("rst seg", 32'(seg), 32'h0000007F);
    check("rst dp", 32'(dp), 1);
    rst_n = 1'b1;

    // 1: seconds 30, score 0 -> tens blanked on digit 3
    push_frame("t1", S0, S3, S0, SB, 1'b1, 1'b0, 1);

    // 2: score saturation
    score = 7'd127;
    settle(16);
    push_frame("t2", S0, S3, S9, S9, 1'b1, 1'b0, 1);

    // 3: warning threshold
    seconds = 5'd6;
    settle(16);
    push_frame("t3 six", S6, S0, S9, S9, 1'b1, 1'b0, 1);
    seconds = 5'd5;
    settle(16);
    push_frame("t3 five", S5, S0, S9, S9, 1'b0, 1'b0, 1);

    // 4: game over blinking, two consecutive frames of opposite phase
    game_over = 1'b1;
    seconds   = 5'd0;
    settle(16);
    push_frame("t4", S0, S0, S9, S9, 1'b1, 1'b1, 2);

    // 5: score changes while a conversion is in progress
    game_over = 1'b0;
    seconds   = 5'd30;
    score     = 7'd0;
    settle(20);
    score = 7'd17;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    score   = 7'd42;
    first17 = -1;
    first42 = -1;
    mixed   = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      v = {dut.bcd_score_tens, dut.bcd_score_ones};
      if (v == 8'h17 && first17 < 0) first17 = i;
      if (v == 8'h42 && first42 < 0) first42 = i;
      if (!(v == 8'h00 || v == 8'h17 || v == 8'h42)) mixed++;
    end
    check("t5 17 settles", 32'(first17 >= 0 && first17 <= 10), 1);
    check("t5 42 follows", 32'(first17 >= 0 && first42 > first17 && first42 - first17 <= 12), 1);
    check("t5 mixed digits", 32'(mixed), 0);
    push_frame("t5", S0, S3, S2, S4, 1'b1, 1'b0, 1);

    // 6: async reset in the middle of the scan
    wait_an(4'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async an", 32'(an), 32'h0000000F);
    check("t6 async seg", 32'(seg), 32'h0000007F);
    check("t6 async dp", 32'(dp), 1);
    settle(2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6 restart an", 32'(an), 32'h0000000E);
    settle(16);
    push_frame("t6", S0, S3, S2, S4, 1'b1, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
